// File: rtl/routine_sequencer_pkg.sv
// Shared definitions for the routine sequencer: the routine bus field map,
// the sequencer state encoding and the registered pin bundle.
package routine_sequencer_pkg;

  localparam int RTN_BUS_W = 47;
  localparam int DONE_BIT  = 46;
  localparam int RED_HI    = 45;
  localparam int RED_LO    = 36;
  localparam int GRN_HI    = 35;
  localparam int GRN_LO    = 28;
  localparam int HEX3_HI   = 27;
  localparam int HEX3_LO   = 21;
  localparam int HEX2_HI   = 20;
  localparam int HEX2_LO   = 14;
  localparam int HEX1_HI   = 13;
  localparam int HEX1_LO   = 7;
  localparam int HEX0_HI   = 6;
  localparam int HEX0_LO   = 0;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    RUN   = 2'd1,
    BLANK = 2'd2
  } seq_state_t;

  typedef struct packed {
    logic [9:0] red;
    logic [7:0] grn;
    logic [6:0] hex3;
    logic [6:0] hex2;
    logic [6:0] hex1;
    logic [6:0] hex0;
  } pins_t;

  // The done flag is deliberately not part of the pin bundle.
  function automatic pins_t bus_to_pins(input logic [RTN_BUS_W-1:0] bus);
    pins_t p;
    p.red  = bus[RED_HI:RED_LO];
    p.grn  = bus[GRN_HI:GRN_LO];
    p.hex3 = bus[HEX3_HI:HEX3_LO];
    p.hex2 = bus[HEX2_HI:HEX2_LO];
    p.hex1 = bus[HEX1_HI:HEX1_LO];
    p.hex0 = bus[HEX0_HI:HEX0_LO];
    return p;
  endfunction

  function automatic pins_t blank_pins(input logic [6:0] hex_code);
    pins_t p;
    p.red  = '0;
    p.grn  = '0;
    p.hex3 = hex_code;
    p.hex2 = hex_code;
    p.hex1 = hex_code;
    p.hex0 = hex_code;
    return p;
  endfunction

endpackage

// File: rtl/routine_sequencer_next_edge_sync.sv
// Two-flop synchroniser followed by a rising-edge detector for an asynchronous
// level input such as a board push button; o_edge is one Clock cycle wide.
module next_edge_sync (
  input  logic Clock,
  input  logic Reset,
  input  logic i_level,
  output logic o_edge
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  // NOTE: non-blocking assignments so each stage samples the previous stage's old value.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_prev <= 1'b0;
    end else begin
      r_meta <= i_level;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_edge = r_sync & ~r_prev;

endmodule

// File: rtl/routine_sequencer.sv
// Selects one of NUM_RTN light-routine buses, drives the board LEDs and hex
// digits from it, and steps to the next routine on done or a Next press.
module routine_sequencer
  import routine_sequencer_pkg::*;
#(
  parameter int         NUM_RTN      = 4,
  parameter int         BLANK_CYCLES = 3,
  parameter logic [6:0] HEX_BLANK    = 7'h7F
) (
  input  logic                           Clock,
  input  logic                           Reset,
  input  logic [RTN_BUS_W*NUM_RTN-1:0]   RtnBus,
  input  logic                           Next,
  input  logic                           Hold,
  output logic [NUM_RTN-1:0]             RtnReset,
  output logic [2:0]                     ActiveRtn,
  output logic [9:0]                     LedRed,
  output logic [7:0]                     LedGrn,
  output logic [6:0]                     Hex3,
  output logic [6:0]                     Hex2,
  output logic [6:0]                     Hex1,
  output logic [6:0]                     Hex0
);

  localparam int                  CNT_W      = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0]    CNT_LOAD   = CNT_W'(BLANK_CYCLES);
  localparam logic [CNT_W-1:0]    CNT_ONE    = CNT_W'(1);
  localparam logic [2:0]          LAST_RTN   = 3'(NUM_RTN - 1);
  localparam logic [NUM_RTN-1:0]  ALL_PARKED = '1;

  seq_state_t              r_state;
  logic [2:0]              r_active;
  logic [CNT_W-1:0]        r_cnt;
  pins_t                   r_pins;
  logic [NUM_RTN-1:0]      r_rtn_reset;

  logic [RTN_BUS_W-1:0]    w_sel_bus;
  logic                    w_next_edge;
  logic                    w_advance;
  logic [2:0]              w_active_inc;

  // Every routine except idx is held in reset.
  function automatic logic [NUM_RTN-1:0] park_mask(input logic [2:0] idx);
    logic [NUM_RTN-1:0] m;
    for (int i = 0; i < NUM_RTN; i++) m[i] = (3'(i) != idx);
    return m;
  endfunction

  next_edge_sync u_next_sync (
    .Clock   (Clock),
    .Reset   (Reset),
    .i_level (Next),
    .o_edge  (w_next_edge)
  );

  // NOTE: default assignment first so no path through the block leaves w_sel_bus unassigned (no latch).
  always_comb begin
    w_sel_bus = '0;
    for (int i = 0; i < NUM_RTN; i++) begin
      if (r_active == 3'(i)) w_sel_bus = RtnBus[i*RTN_BUS_W +: RTN_BUS_W];
    end
  end

  assign w_advance    = (w_sel_bus[DONE_BIT] & ~Hold) | w_next_edge;
  assign w_active_inc = (r_active == LAST_RTN) ? 3'd0 : r_active + 3'd1;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state     <= LOAD;
      r_active    <= 3'd0;
      r_cnt       <= '0;
      r_pins      <= blank_pins(HEX_BLANK);
      r_rtn_reset <= ALL_PARKED;
    end else begin
      case (r_state)
        LOAD: begin
          r_state     <= RUN;
          r_rtn_reset <= park_mask(r_active);
          r_pins      <= bus_to_pins(w_sel_bus);
        end
        RUN: begin
          if (w_advance) begin
            r_active <= w_active_inc;
            r_cnt    <= CNT_LOAD;
            r_pins   <= blank_pins(HEX_BLANK);
            if (BLANK_CYCLES > 0) begin
              r_state     <= BLANK;
              r_rtn_reset <= park_mask(w_active_inc);
            end else begin
              r_state     <= LOAD;
              r_rtn_reset <= ALL_PARKED;
            end
          end else begin
            r_pins <= bus_to_pins(w_sel_bus);
          end
        end
        BLANK: begin
          r_pins <= blank_pins(HEX_BLANK);
          // A zero count can only come from corruption; leave BLANK rather than wrap.
          if (r_cnt == CNT_ONE || r_cnt == '0) begin
            r_state     <= LOAD;
            r_rtn_reset <= ALL_PARKED;
          end else begin
            r_cnt <= r_cnt - CNT_ONE;
          end
        end
        default: begin
          r_state     <= LOAD;
          r_active    <= 3'd0;
          r_cnt       <= '0;
          r_pins      <= blank_pins(HEX_BLANK);
          r_rtn_reset <= ALL_PARKED;
        end
      endcase
    end
  end

  assign RtnReset  = r_rtn_reset;
  assign ActiveRtn = r_active;
  assign LedRed    = r_pins.red;
  assign LedGrn    = r_pins.grn;
  assign Hex3      = r_pins.hex3;
  assign Hex2      = r_pins.hex2;
  assign Hex1      = r_pins.hex1;
  assign Hex0      = r_pins.hex0;

endmodule
